// File: rtl/apb_pkg.sv
// Shared types and address-decode helper for the APB slave memory.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, READY} apb_state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Out-of-window, misaligned or beyond-depth byte addresses are errors.
  function automatic logic apb_addr_err(input logic [APB_ADDR_W-1:0] addr,
                                        input logic [APB_ADDR_W-1:0] base,
                                        input int unsigned           depth);
    logic [APB_ADDR_W-1:0] off;
    off = addr - base;
    return (addr < base) || (off[1:0] != 2'b00) ||
           ((off >> 2) >= APB_ADDR_W'(depth));
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the master stage and the slave memory.
interface apb_slave_mem_if #(
  parameter int ADDR_W = apb_pkg::APB_ADDR_W,
  parameter int DATA_W = apb_pkg::APB_DATA_W
);
  logic              psel;
  logic              pen;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output psel, pen, paddr, pwrite, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, pen, paddr, pwrite, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W word store: one synchronous write port, one combinational read port.
module apb_slave_regfile #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we && (int'(widx) < DEPTH)) mem_d[widx] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = (int'(ridx) < DEPTH) ? mem_q[ridx] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave backed by a word memory, with programmable wait states and pslverr on bad addresses.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int              ADDR_W      = APB_ADDR_W,
  parameter int              DATA_W      = APB_DATA_W,
  parameter int              DEPTH       = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              WAIT_CYCLES = 0
) (
  input logic            pclk,
  input logic            prst_n,
  apb_slave_mem_if.slave bus
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  apb_state_e        state_q,   state_d;
  logic [3:0]        cnt_q,     cnt_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic              write_q,   write_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic              err_q,     err_d;
  logic              pready_q,  pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q,  prdata_d;

  logic              err_now;
  logic [IDX_W-1:0]  idx_now;
  logic [IDX_W-1:0]  ridx;
  logic [DATA_W-1:0] rdata;
  logic              mem_we;

  always_comb begin
    err_now = apb_addr_err(APB_ADDR_W'(bus.paddr), APB_ADDR_W'(BASE_ADDR), DEPTH);
    idx_now = IDX_W'((APB_ADDR_W'(bus.paddr) - APB_ADDR_W'(BASE_ADDR)) >> 2);
    // Zero-wait reads sample the array with the live setup address.
    ridx    = (state_q == IDLE) ? idx_now : idx_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.psel && !bus.pen) begin
          idx_d   = idx_now;
          write_d = bus.pwrite;
          wdata_d = bus.pwdata;
          err_d   = err_now;
          if (WAIT_CYCLES == 0) begin
            state_d   = READY;
            pready_d  = 1'b1;
            pslverr_d = err_now;
            prdata_d  = (!bus.pwrite && !err_now) ? rdata : '0;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end

      WAIT: begin
        if (!bus.psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d   = READY;
          cnt_d     = '0;
          pready_d  = 1'b1;
          pslverr_d = err_q;
          prdata_d  = (!write_q && !err_q) ? rdata : '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      READY: begin
        if (!bus.psel || bus.pen) begin
          mem_we    = bus.psel && write_q && !err_q;
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  apb_slave_regfile #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk   (pclk),
    .rst_n (prst_n),
    .we    (mem_we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .ridx  (ridx),
    .rdata (rdata)
  );

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: a zero-wait and a three-wait instance share one stimulus driver.
module tb_apb_slave_mem;
  import apb_pkg::*;

  localparam int DEPTH = 16;

  logic        pclk = 1'b0;
  logic        prst_n;
  logic        psel, pen, pwrite;
  logic [31:0] paddr, pwdata;
  int          sel;

  always #5 pclk = ~pclk;

  apb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  apb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

  assign bus0.psel   = psel && (sel == 0);
  assign bus0.pen    = pen  && (sel == 0);
  assign bus0.paddr  = paddr;
  assign bus0.pwrite = pwrite;
  assign bus0.pwdata = pwdata;
  assign bus3.psel   = psel && (sel == 1);
  assign bus3.pen    = pen  && (sel == 1);
  assign bus3.paddr  = paddr;
  assign bus3.pwrite = pwrite;
  assign bus3.pwdata = pwdata;

  apb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(0))
    dut0 (.pclk(pclk), .prst_n(prst_n), .bus(bus0));
  apb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_CYCLES(3))
    dut3 (.pclk(pclk), .prst_n(prst_n), .bus(bus3));

  logic        pready, pslverr;
  logic [31:0] prdata;
  assign pready  = (sel == 1) ? bus3.pready  : bus0.pready;
  assign pslverr = (sel == 1) ? bus3.pslverr : bus0.pslverr;
  assign prdata  = (sel == 1) ? bus3.prdata  : bus0.prdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          mon_waits = 0;
  logic [31:0] model [2][DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s (dut%0d): got %h, expected %h", name, sel, act, req);
    end
  endtask

  function automatic int wait_states();
    return (sel == 1) ? 3 : 0;
  endfunction

  // Reference: word memory indexed by byte address / 4, bad addresses answer with pslverr and zero data.
  function automatic exp_t predict(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    int   idx;
    idx     = int'(addr / 4);
    e.err   = (addr % 4 != 0) || (addr / 4 >= DEPTH);
    e.waits = wait_states();
    e.rdata = (!wr && !e.err) ? model[sel][idx] : 32'h0;
    if (wr && !e.err) model[sel][idx] = data;
    return e;
  endfunction

  always @(negedge pclk) begin
    if (prst_n) begin
      if (!psel) begin
        mon_waits = 0;
      end else if (pen) begin
        if (pready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_pready", 32'd1, 32'd0);
          end else begin
            mon_e = sb_q.pop_front();
            check("prdata", prdata, mon_e.rdata);
            check("pslverr", 32'(pslverr), 32'(mon_e.err));
            check("wait_states", 32'(mon_waits), 32'(mon_e.waits));
          end
          mon_waits = 0;
        end else begin
          mon_waits++;
        end
      end else begin
        check("setup_pready", 32'(pready), 32'd0);
      end
    end
  end

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data, input bit last);
    bit done;
    sb_q.push_back(predict(wr, addr, data));
    psel   = 1'b1;
    pen    = 1'b0;
    paddr  = addr;
    pwrite = wr;
    pwdata = data;
    @(posedge pclk); #1;
    pen    = 1'b1;
    // Access-phase bus changes must not affect the latched transfer.
    paddr  = $urandom;
    pwdata = $urandom;
    pwrite = 1'($urandom);
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge pclk);
      if (pready) done = 1'b1;
      @(posedge pclk); #1;
    end
    if (!done) check("xfer_timeout", 32'd0, 32'd1);
    pen = 1'b0;
    if (last) psel = 1'b0;
  endtask

  task automatic directed();
    xfer(1'b0, 32'h4,  32'h0,        1'b1);
    xfer(1'b1, 32'h8,  32'hDEADBEEF, 1'b0);
    xfer(1'b0, 32'h8,  32'h0,        1'b1);
    xfer(1'b1, 32'h40, 32'h55,       1'b0);
    xfer(1'b0, 32'h40, 32'h0,        1'b1);
    xfer(1'b1, 32'h4,  32'h1234_5678, 1'b1);
    xfer(1'b1, 32'h6,  32'hFFFF_FFFF, 1'b0);
    xfer(1'b0, 32'h4,  32'h0,        1'b1);
    for (int a = 0; a < DEPTH; a++) xfer(1'b0, 32'(a * 4), 32'h0, a == DEPTH - 1);
  endtask

  initial begin
    sel    = 0;
    psel   = 1'b0;
    pen    = 1'b0;
    paddr  = '0;
    pwrite = 1'b0;
    pwdata = '0;
    prst_n = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) model[s][i] = 32'h0;

    repeat (3) @(posedge pclk); #1;
    check("rst_pready0",  32'(bus0.pready),  32'd0);
    check("rst_pslverr0", 32'(bus0.pslverr), 32'd0);
    check("rst_prdata0",  bus0.prdata,       32'd0);
    check("rst_pready3",  32'(bus3.pready),  32'd0);
    check("rst_pslverr3", 32'(bus3.pslverr), 32'd0);
    check("rst_prdata3",  bus3.prdata,       32'd0);
    prst_n = 1'b1;
    @(posedge pclk); #1;

    for (int s = 0; s < 2; s++) begin
      sel = s;
      directed();
      @(posedge pclk); #1;
    end

    // Enable asserted without a setup phase is ignored.
    sel  = 0;
    psel = 1'b1;
    pen  = 1'b1;
    paddr = 32'h8;
    repeat (3) begin
      @(negedge pclk);
      check("idle_violation_pready", 32'(pready), 32'd0);
      @(posedge pclk); #1;
    end
    psel = 1'b0;
    pen  = 1'b0;
    @(posedge pclk); #1;

    // Abort during wait states: no response, no write.
    sel = 1;
    xfer(1'b1, 32'h0, 32'hA5A5_A5A5, 1'b1);
    psel   = 1'b1;
    paddr  = 32'h0;
    pwrite = 1'b1;
    pwdata = 32'h1111_1111;
    @(posedge pclk); #1;
    pen = 1'b1;
    @(negedge pclk);
    check("abort_pready_wait", 32'(pready), 32'd0);
    @(posedge pclk); #1;
    psel = 1'b0;
    pen  = 1'b0;
    repeat (2) begin
      @(negedge pclk);
      check("abort_pready_idle", 32'(pready), 32'd0);
      @(posedge pclk); #1;
    end
    xfer(1'b0, 32'h0, 32'h0, 1'b1);

    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int n = 0; n < 80; n++) begin
        logic [31:0] a;
        a = 32'($urandom_range(0, 17) * 4);
        if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
        xfer(1'($urandom), a, $urandom, ($urandom_range(0, 2) == 0) || (n == 79));
      end
      @(posedge pclk); #1;
    end

    // Asynchronous reset while a response is being presented.
    sel = 1;
    xfer(1'b1, 32'h8, 32'hC0FF_EE01, 1'b1);
    sb_q.push_back(predict(1'b0, 32'h8, 32'h0));
    psel   = 1'b1;
    pen    = 1'b0;
    paddr  = 32'h8;
    pwrite = 1'b0;
    @(posedge pclk); #1;
    pen = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    @(negedge pclk);
    #2;
    prst_n = 1'b0;
    #1;
    check("async_rst_pready",  32'(bus3.pready),  32'd0);
    check("async_rst_prdata",  bus3.prdata,       32'd0);
    check("async_rst_pslverr", 32'(bus3.pslverr), 32'd0);
    psel = 1'b0;
    pen  = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++) model[s][i] = 32'h0;
    @(posedge pclk); #1;
    prst_n = 1'b1;
    @(posedge pclk); #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int a = 0; a < DEPTH; a++) xfer(1'b0, 32'(a * 4), 32'h0, a == DEPTH - 1);
    end

    repeat (4) @(posedge pclk);
    #1;
    if (sb_q.size() != 0) check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
